// File: rtl/wrr_sched_if.sv
// wrr_sched_if -- bundle between requesters and the weighted round-robin
// scheduler.
//
// Signals:
//   req        requester -> scheduler   N-bit request vector
//   weight     requester -> scheduler   N x CW quota fields, field i = weight[i*CW +: CW]
//   res_ready  resource  -> scheduler   resource accepts one beat this cycle
//   gnt        scheduler -> requester   registered one-hot grant (all-zero when idle)
//   gnt_id     scheduler -> requester   binary index of the owner (0 when idle)
//   busy       scheduler -> requester   a grant is held
//   beat       scheduler -> requester   one beat consumed this cycle (combinational)
//   dbg_state  scheduler -> observer    1 = GRANT, 0 = IDLE
//   dbg_ptr    scheduler -> observer    rotation pointer
//   dbg_cnt    scheduler -> observer    beats consumed in the current grant
//
// Handshake: a beat is transferred in any cycle where busy, res_ready and
// req[gnt_id] are all high; the scheduler flags it on beat. Neither side
// waits on the other combinationally except through beat.
interface wrr_sched_if #(
  parameter int W  = 2,
  parameter int CW = 4
);
  localparam int N = 2 ** W;

  logic [N-1:0]    req;
  logic [N*CW-1:0] weight;
  logic            res_ready;
  logic [N-1:0]    gnt;
  logic [W-1:0]    gnt_id;
  logic            busy;
  logic            beat;
  logic            dbg_state;
  logic [W-1:0]    dbg_ptr;
  logic [CW-1:0]   dbg_cnt;

  // Requester / environment side.
  modport master (
    output req, weight, res_ready,
    input  gnt, gnt_id, busy, beat, dbg_state, dbg_ptr, dbg_cnt
  );

  // Scheduler side.
  modport slave (
    input  req, weight, res_ready,
    output gnt, gnt_id, busy, beat, dbg_state, dbg_ptr, dbg_cnt
  );
endinterface

// File: rtl/wrr_sched.sv
// wrr_sched -- weighted round-robin scheduler for N = 2**W requesters.
//
// A requester that wins arbitration keeps the shared resource for up to its
// latched quota of beats (quota 0 counts as 1), or until it drops its
// request. On release the next winner is chosen in the same cycle, scanning
// upward from the requester after the previous owner, so there is no idle
// bubble between grants.
//
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    wrr_sched_if.slave (req, weight, res_ready in;
//          gnt, gnt_id, busy, beat, debug state out)
module wrr_sched #(
  parameter int W  = 2,
  parameter int CW = 4
) (
  input  logic        clock,
  input  logic        reset,
  wrr_sched_if.slave  bus
);
  localparam int N = 2 ** W;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] quota_q, quota_d;
  logic [W-1:0]  owner_q, owner_d;
  logic [N-1:0]  gnt_q, gnt_d;

  logic [W-1:0]  scan_base;
  logic [W-1:0]  winner;
  logic [CW-1:0] winner_weight;
  logic          any_req;
  logic          busy;
  logic          beat;
  logic          quota_done;
  logic          release_now;

  // First set bit of r scanning upward from base; W-bit arithmetic gives the
  // modulo-N wrap for free.
  function automatic logic [W-1:0] pick(input logic [N-1:0] r,
                                        input logic [W-1:0] base);
    logic [W-1:0] idx;
    logic [W-1:0] res;
    logic         found;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = base + W'(k);
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign busy    = (state_q == GRANT);
  assign beat    = busy & bus.res_ready & bus.req[owner_q];
  assign any_req = |bus.req;

  // While idle the scan starts at ptr; in the release cycle it starts just
  // past the owner, which is exactly the value ptr takes at that edge.
  assign scan_base     = busy ? (owner_q + W'(1)) : ptr_q;
  assign winner        = pick(bus.req, scan_base);
  assign winner_weight = bus.weight[int'(winner) * CW +: CW];

  // cnt never exceeds quota-1, but widen anyway so cnt+1 cannot wrap.
  assign quota_done  = beat && (({1'b0, cnt_q} + 1'b1) == {1'b0, quota_q});
  assign release_now = busy && (!bus.req[owner_q] || quota_done);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    quota_d = quota_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          owner_d = winner;
          gnt_d   = N'(1) << winner;
          cnt_d   = '0;
          quota_d = (winner_weight == '0) ? CW'(1) : winner_weight;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d = owner_q + W'(1);
          cnt_d = '0;
          if (any_req) begin
            // Back-to-back hand-off; a lone requester re-wins itself here.
            owner_d = winner;
            gnt_d   = N'(1) << winner;
            quota_d = (winner_weight == '0) ? CW'(1) : winner_weight;
          end else begin
            state_d = IDLE;
            owner_d = '0;
            gnt_d   = '0;
          end
        end else if (beat) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      quota_q <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      quota_q <= quota_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = owner_q;
  assign bus.busy      = busy;
  assign bus.beat      = beat;
  assign bus.dbg_state = (state_q == GRANT);
  assign bus.dbg_ptr   = ptr_q;
  assign bus.dbg_cnt   = cnt_q;
endmodule

// File: tb/tb_wrr_sched.sv
module tb_wrr_sched;
  localparam int W  = 2;
  localparam int CW = 4;
  localparam int N  = 2 ** W;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  wrr_sched_if #(.W(W), .CW(CW)) bus ();

  wrr_sched #(.W(W), .CW(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Packed observation {gnt, gnt_id, busy, beat}.
  function automatic logic [7:0] observe();
    return {bus.gnt, bus.gnt_id, bus.busy, bus.beat};
  endfunction

  task automatic chk_onehot(input string name);
    n_checks++;
    if (!$onehot0(bus.gnt)) begin
      n_fail++;
      $display("FAIL %s onehot: gnt=%b", name, bus.gnt);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [N-1:0] r, input logic [N*CW-1:0] w, input logic rdy);
    bus.req       = r;
    bus.weight    = w;
    bus.res_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Holds reset over two edges, releases it after a falling edge.
  task automatic do_reset(input logic [N-1:0] r);
    reset = 1'b0;
    drive(r, '0, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0]    req;
    logic [N*CW-1:0] weight;
    logic            rdy;
    logic [N-1:0]    e_gnt;
    logic [W-1:0]    e_id;
    logic            e_busy;
    logic            e_beat;
  } vec_t;

  vec_t tbl[18];

  initial begin
    // Full rotation with weight 2 each, no bubble, then wrap back to 0.
    tbl[0]  = '{4'hF, 16'h2222, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[1]  = '{4'hF, 16'h2222, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[2]  = '{4'hF, 16'h2222, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[3]  = '{4'hF, 16'h2222, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[4]  = '{4'hF, 16'h2222, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[5]  = '{4'hF, 16'h2222, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[6]  = '{4'hF, 16'h2222, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1};
    tbl[7]  = '{4'hF, 16'h2222, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1};
    tbl[8]  = '{4'hF, 16'h2222, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[9]  = '{4'hF, 16'h2222, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};
    // Owner drops with nobody else requesting -> idle.
    tbl[10] = '{4'h0, 16'h2222, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    // Lone requester, weight 0 -> quota 1, re-granted every beat.
    tbl[11] = '{4'h1, 16'h0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[12] = '{4'h1, 16'h0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[13] = '{4'h1, 16'h0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[14] = '{4'h0, 16'h0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    // ptr=1 after the last release; requesters 1 and 2 alternate.
    tbl[15] = '{4'h6, 16'h0110, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[16] = '{4'h6, 16'h0110, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[17] = '{4'h6, 16'h0110, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1};
  end

  // ---------------- test ----------------
  initial begin
    logic [7:0] exp_v;
    logic [7:0] act_v;

    // Reset with all requesting; nothing granted until the first edge.
    do_reset(4'hF);
    chk("rst_gnt_in_reset_release", 32'(bus.gnt), 32'h0);
    chk("rst_busy_pre_edge", 32'(bus.busy), 32'h0);
    chk("rst_ptr", 32'(bus.dbg_ptr), 32'h0);
    chk("rst_cnt", 32'(bus.dbg_cnt), 32'h0);
    tick();
    chk("first_gnt", 32'(bus.gnt), 32'h1);
    chk("first_id", 32'(bus.gnt_id), 32'h0);
    chk("first_busy", 32'(bus.busy), 32'h1);

    // Table-driven run.
    do_reset(4'h0);
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].req, tbl[i].weight, tbl[i].rdy);
      exp_q.push_back({tbl[i].e_gnt, tbl[i].e_id, tbl[i].e_busy, tbl[i].e_beat});
      tick();
      act_v = observe();
      exp_v = exp_q.pop_front();
      chk($sformatf("row%0d {gnt,id,busy,beat}", i), 32'(act_v), 32'(exp_v));
      chk_onehot($sformatf("row%0d", i));
    end

    // Stall: res_ready low for 10 cycles holds the grant, cnt frozen.
    do_reset(4'h0);
    drive(4'b0011, 16'h0003, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      chk($sformatf("stall%0d_gnt", i), 32'(bus.gnt), 32'h1);
      chk($sformatf("stall%0d_beat", i), 32'(bus.beat), 32'h0);
    end
    chk("stall_cnt", 32'(bus.dbg_cnt), 32'h0);
    bus.res_ready = 1'b1;
    tick();
    chk("stall_b1_gnt", 32'(bus.gnt), 32'h1);
    chk("stall_b1_cnt", 32'(bus.dbg_cnt), 32'h1);
    tick();
    chk("stall_b2_gnt", 32'(bus.gnt), 32'h1);
    tick();
    chk("stall_b3_gnt", 32'(bus.gnt), 32'h2);
    chk("stall_b3_id", 32'(bus.gnt_id), 32'h1);
    chk("stall_b3_cnt", 32'(bus.dbg_cnt), 32'h0);

    // Owner drops after one beat of an 8-beat quota.
    do_reset(4'h0);
    drive(4'b0101, 16'h0008, 1'b1);
    tick();
    chk("drop_gnt0", 32'(bus.gnt), 32'h1);
    tick();
    chk("drop_cnt1", 32'(bus.dbg_cnt), 32'h1);
    bus.req = 4'b0100;
    // Non-owner weight change mid-grant must not matter either.
    bus.weight = 16'h0F08;
    tick();
    chk("drop_gnt", 32'(bus.gnt), 32'h4);
    chk("drop_id", 32'(bus.gnt_id), 32'h2);
    chk("drop_cnt", 32'(bus.dbg_cnt), 32'h0);
    chk("drop_ptr", 32'(bus.dbg_ptr), 32'h1);

    // Asynchronous reset mid-burst.
    do_reset(4'h0);
    drive(4'hF, 16'h2222, 1'b1);
    repeat (3) tick();
    chk("async_pre_gnt", 32'(bus.gnt), 32'h2);
    #2;
    reset = 1'b0;
    #1;
    chk("async_gnt", 32'(bus.gnt), 32'h0);
    chk("async_busy", 32'(bus.busy), 32'h0);
    chk("async_beat", 32'(bus.beat), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk("async_restart_gnt", 32'(bus.gnt), 32'h1);
    chk("async_restart_id", 32'(bus.gnt_id), 32'h0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
